majority_vote_stream: RTL and testbench
=======================================

Name: majority_vote_stream

Overview:
Parametrised, pipelined k-of-N bitwise voter. It is the sequential successor to the fixed 5-input majority gate. It accepts N voter words per beat over valid/ready and produces, per bit position, 1 when at least THR voters agree. It also keeps a saturating count of non-unanimous beats. It sits between redundant producers (TMR/5MR lanes) and a single consumer.

Parameters:
N_INPUTS, 5, number of voters (3..31)
DATA_W, 4, bits per voter word
CNT_W, 16, width of the dissent counter
CW, clog2(N_INPUTS+1), derived; popcount/threshold width (localparam, not overridable)

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  input beat valid
in_ready  out  1  block can accept a beat
in_data  in  N_INPUTS*DATA_W  voter i at [i*DATA_W +: DATA_W]
in_thr  in  CW  threshold for this beat; 0 selects strict majority
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
out_data  out  DATA_W  voted word
out_unan  out  1  all voters agreed on every bit of this beat
dissent_cnt  out  CNT_W  saturating count of delivered non-unanimous beats
cnt_clr  in  1  synchronous clear of dissent_cnt

Behaviour:
- Reset (rst_n=0, async) forces the following to 0: both stage valids, out_valid, out_data, out_unan and dissent_cnt. Any in-flight beats are discarded. in_ready=1 from the first cycle after release.
- Input handshake: a beat is accepted when in_valid & in_ready. in_thr is sampled with the beat.
- Effective threshold T: if in_thr==0, T = N_INPUTS/2+1 (integer division). Otherwise T = in_thr. If T > N_INPUTS, every output bit is 0.
- Stage 1 (registered):
  - per bit b, cnt[b] = number of voters with bit b set (CW bits, no overflow by construction).
  - unan = 1 iff every cnt[b] is 0 or N_INPUTS.
  - T is stored alongside.
- Stage 2 (registered output): out_data[b] = (cnt[b] >= T). out_unan = unan.
- Latency: 2 cycles from acceptance to out_valid with no backpressure. Throughput is 1 beat/cycle.
- Flow control:
  - Stage 2 loads when it is empty or out_ready=1.
  - Stage 1 loads when it is empty or stage 2 loads.
  - in_ready = !s1_valid | stage-2-load. This is combinational from out_ready; there is no path from in_valid.
  - With out_ready=0, at most 2 beats are held. in_ready falls once both stages are full.
  - Payload is stable while out_valid=1 and out_ready=0.
  - Order is preserved. No beat is dropped or duplicated.
- Dissent counter:
  - Increments by 1 on each output handshake (out_valid & out_ready) where out_unan=0.
  - Saturates at 2^CNT_W-1; no wrap.
  - cnt_clr=1 sets it to 0 next cycle. Clear wins over a simultaneous increment.
- Simultaneous input accept and output handshake in the same cycle is legal and keeps full throughput.
- N_INPUTS=1: T defaults to 1, every beat is unanimous, and out_data equals the input.

Decomposition:
- Package majority_vote_pkg holds:
  - clog2 function;
  - default_thr(n) function returning n/2+1;
  - a struct typedef for the stage-1 payload {cnt array, unan, thr}.
- One sub-module, maj_popcount: combinational count of set bits across N_INPUTS for one bit column. It is instantiated DATA_W times in stage 1.

Test Plan:
1. Reset then idle -> in_ready=1, out_valid=0, out_data=0000, dissent_cnt=0.
2. N=5, W=4. Voters v0..v4 = 1010,1100,1001,0000,1111 with thr=0 (T=3), out_ready=1 -> 2 cycles later out_data=1000, out_unan=0. dissent_cnt becomes 1 after the handshake.
3. Same voters with thr=1 -> 1111; thr=2 -> 1111; thr=4 -> 1000; thr=5 -> 0000; thr=7 (>N) -> 0000. Results arrive back-to-back, one per cycle, in order.
4. out_ready=0 with 3 consecutive valid beats -> first two accepted, in_ready=0 on the third. out_data holds beat 1 stable. After releasing out_ready, beats 1,2,3 emerge in order on consecutive cycles.
5. All voters 1111 -> out_data=1111, out_unan=1, counter unchanged. With CNT_W=2, five dissenting beats -> dissent_cnt=3 (saturated). cnt_clr asserted together with a dissenting handshake -> 0.
6. Assert rst_n=0 asynchronously with both stages full -> out_valid drops immediately without waiting for a clock. After release, no stale beat appears and dissent_cnt=0.

Source files
------------

// File: rtl/majority_vote_pkg.sv
// Shared types and helpers for the k-of-N streaming majority voter.
// Stage-1 payload is sized for the largest supported configuration (N <= 31, DATA_W <= 32).
package majority_vote_pkg;

  localparam int unsigned MAX_CW     = 5;
  localparam int unsigned MAX_DATA_W = 32;

  typedef logic [MAX_CW-1:0] cnt_t;

  typedef struct packed {
    cnt_t [MAX_DATA_W-1:0] cnt;
    logic                  unan;
    cnt_t                  thr;
  } s1_payload_t;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

  function automatic int unsigned default_thr(input int unsigned n);
    return n / 2 + 1;
  endfunction

endpackage

// File: rtl/maj_popcount.sv
// Combinational population count of one bit column across all voters.
module maj_popcount
  import majority_vote_pkg::*;
#(
  parameter  int unsigned N_INPUTS = 5,
  localparam int unsigned CW       = clog2(N_INPUTS + 1)
) (
  input  logic [N_INPUTS-1:0] bits_i,
  output logic [CW-1:0]       count_c
);

  always_comb begin
    count_c = '0;
    for (int unsigned i = 0; i < N_INPUTS; i++) begin
      count_c = count_c + CW'(bits_i[i]);
    end
  end

endmodule

// File: rtl/majority_vote_stream.sv
// Two-stage pipelined k-of-N bitwise voter with valid/ready flow control
// and a saturating count of delivered non-unanimous beats.
module majority_vote_stream
  import majority_vote_pkg::*;
#(
  parameter  int unsigned N_INPUTS = 5,
  parameter  int unsigned DATA_W   = 4,
  parameter  int unsigned CNT_W    = 16,
  localparam int unsigned CW       = clog2(N_INPUTS + 1)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [N_INPUTS*DATA_W-1:0] in_data,
  input  logic [CW-1:0]              in_thr,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_W-1:0]          out_data,
  output logic                       out_unan,
  output logic [CNT_W-1:0]           dissent_cnt,
  input  logic                       cnt_clr
);

  logic [DATA_W-1:0][CW-1:0] col_cnt_c;
  logic                      unan_c;
  logic [MAX_CW-1:0]         thr_c;
  logic                      s1_load_c;
  logic                      s2_load_c;
  logic                      accept_c;
  logic                      out_hs_c;
  logic [DATA_W-1:0]         vote_c;
  logic                      unused_cnt_c;

  logic                      s1_valid_q, s1_valid_d;
  s1_payload_t               s1_q, s1_d;
  logic                      out_valid_q, out_valid_d;
  logic [DATA_W-1:0]         out_data_q, out_data_d;
  logic                      out_unan_q, out_unan_d;
  logic [CNT_W-1:0]          dissent_cnt_q, dissent_cnt_d;

  // One popcount per bit column; voter i owns in_data[i*DATA_W +: DATA_W].
  for (genvar b = 0; b < DATA_W; b++) begin : g_col
    logic [N_INPUTS-1:0] col;
    logic [CW-1:0]       cnt;
    for (genvar i = 0; i < N_INPUTS; i++) begin : g_bit
      assign col[i] = in_data[i*DATA_W + b];
    end
    maj_popcount #(.N_INPUTS(N_INPUTS)) u_pop (
      .bits_i (col),
      .count_c(cnt)
    );
    assign col_cnt_c[b] = cnt;
  end

  always_comb begin
    s2_load_c = !out_valid_q | out_ready;
    s1_load_c = !s1_valid_q | s2_load_c;
    accept_c  = in_valid & s1_load_c;
    out_hs_c  = out_valid_q & out_ready;
  end

  always_comb begin
    unan_c = 1'b1;
    for (int unsigned b = 0; b < DATA_W; b++) begin
      if (col_cnt_c[b] != '0 && col_cnt_c[b] != CW'(N_INPUTS)) unan_c = 1'b0;
    end
    thr_c = (in_thr == '0) ? MAX_CW'(default_thr(N_INPUTS)) : MAX_CW'(in_thr);
  end

  // Stage 1: column counts, unanimity flag and effective threshold.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_d       = s1_q;
    if (s1_load_c) s1_valid_d = in_valid;
    if (accept_c) begin
      s1_d = '0;
      for (int unsigned b = 0; b < DATA_W; b++) begin
        s1_d.cnt[b] = MAX_CW'(col_cnt_c[b]);
      end
      s1_d.unan = unan_c;
      s1_d.thr  = thr_c;
    end
  end

  // A threshold above N_INPUTS can never be met, so no special case is needed.
  always_comb begin
    vote_c = '0;
    for (int unsigned b = 0; b < DATA_W; b++) begin
      vote_c[b] = (s1_q.cnt[b] >= s1_q.thr);
    end
  end

  // Columns beyond DATA_W are held at zero and never voted on.
  assign unused_cnt_c = ^s1_q.cnt;

  // Stage 2: registered result, held while the consumer stalls.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_unan_d  = out_unan_q;
    if (s2_load_c) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        out_data_d = vote_c;
        out_unan_d = s1_q.unan;
      end
    end
  end

  always_comb begin
    dissent_cnt_d = dissent_cnt_q;
    if (cnt_clr) begin
      dissent_cnt_d = '0;
    end else if (out_hs_c && !out_unan_q && dissent_cnt_q != '1) begin
      dissent_cnt_d = dissent_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q    <= 1'b0;
      s1_q          <= '0;
      out_valid_q   <= 1'b0;
      out_data_q    <= '0;
      out_unan_q    <= 1'b0;
      dissent_cnt_q <= '0;
    end else begin
      s1_valid_q    <= s1_valid_d;
      s1_q          <= s1_d;
      out_valid_q   <= out_valid_d;
      out_data_q    <= out_data_d;
      out_unan_q    <= out_unan_d;
      dissent_cnt_q <= dissent_cnt_d;
    end
  end

  assign in_ready    = s1_load_c;
  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign out_unan    = out_unan_q;
  assign dissent_cnt = dissent_cnt_q;

endmodule

// File: tb/tb_majority_vote_stream.sv
// Directed bench for majority_vote_stream: literal expectations plus a
// queue-based reference model checked on every falling clock edge.
module tb_majority_vote_stream;

  localparam int N    = 5;
  localparam int W    = 4;
  localparam int CNTW = 2;
  localparam int CW   = 3;
  localparam logic [N*W-1:0] VOTERS = {4'b1111, 4'b0000, 4'b1001, 4'b1100, 4'b1010};
  localparam logic [N*W-1:0] ALL1   = '1;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            in_valid;
  logic            in_ready;
  logic [N*W-1:0]  in_data;
  logic [CW-1:0]   in_thr;
  logic            out_valid;
  logic            out_ready;
  logic [W-1:0]    out_data;
  logic            out_unan;
  logic [CNTW-1:0] dissent_cnt;
  logic            cnt_clr;

  majority_vote_stream #(.N_INPUTS(N), .DATA_W(W), .CNT_W(CNTW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_thr     (in_thr),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_unan   (out_unan),
    .dissent_cnt(dissent_cnt),
    .cnt_clr    (cnt_clr)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: a beat's expected result from the voting rules alone.
  typedef struct {
    logic [W-1:0] data;
    logic         unan;
    int           stamp;
  } exp_t;

  function automatic exp_t model(input logic [N*W-1:0] d, input logic [CW-1:0] thr, input int stamp);
    exp_t r;
    int   t;
    int   c;
    t      = (thr == 0) ? (N / 2 + 1) : int'(thr);
    r.unan = 1'b1;
    r.data = '0;
    for (int b = 0; b < W; b++) begin
      c = 0;
      for (int i = 0; i < N; i++) c += int'(d[i*W + b]);
      r.data[b] = (c >= t);
      if (c != 0 && c != N) r.unan = 1'b0;
    end
    r.stamp = stamp;
    return r;
  endfunction

  exp_t q[$];
  int   m_cnt = 0;
  int   cyc   = 0;

  // Every falling edge: check outputs against the model, then advance it.
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      q.delete();
      m_cnt = 0;
    end else begin
      check("m_dissent", 32'(dissent_cnt), 32'(m_cnt));
      check("m_in_ready", 32'(in_ready), 32'((q.size() < 2) || out_ready));
      check("m_out_valid", 32'(out_valid), 32'(q.size() > 0 && (cyc - q[0].stamp) >= 2));
      if (out_valid && q.size() > 0) begin
        check("m_out_data", 32'(out_data), 32'(q[0].data));
        check("m_out_unan", 32'(out_unan), 32'(q[0].unan));
        if (out_ready) begin
          if (!q[0].unan && m_cnt < (1 << CNTW) - 1) m_cnt++;
          void'(q.pop_front());
        end
      end
      if (cnt_clr) m_cnt = 0;
      if (in_valid && in_ready) q.push_back(model(in_data, in_thr, cyc));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int thr_list [5] = '{1, 2, 4, 5, 7};
  int exp_list [5] = '{15, 15, 8, 0, 0};

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_thr = '0;
    out_ready = 1'b0; cnt_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset state
    check("rst_in_ready", 32'(in_ready), 1);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_out_data", 32'(out_data), 0);
    check("rst_dissent", 32'(dissent_cnt), 0);
    tick();

    // Default strict majority and two-cycle latency
    out_ready = 1'b1; in_valid = 1'b1; in_data = VOTERS; in_thr = '0;
    tick();
    in_valid = 1'b0;
    check("lat1_valid", 32'(out_valid), 0);
    tick();
    check("lat2_valid", 32'(out_valid), 1);
    check("maj_data", 32'(out_data), 32'h8);
    check("maj_unan", 32'(out_unan), 0);
    check("maj_cnt_before", 32'(dissent_cnt), 0);
    tick();
    check("maj_cnt_after", 32'(dissent_cnt), 1);
    check("maj_drained", 32'(out_valid), 0);

    // Explicit thresholds, back-to-back
    for (int i = 0; i < 6; i++) begin
      if (i < 5) begin
        in_valid = 1'b1; in_thr = CW'(thr_list[i]);
      end else begin
        in_valid = 1'b0;
      end
      tick();
      if (i >= 1) begin
        check("thr_valid", 32'(out_valid), 1);
        check("thr_data", 32'(out_data), 32'(exp_list[i-1]));
      end
    end
    tick();

    // Backpressure: two beats held, third stalled
    out_ready = 1'b0; in_valid = 1'b1; in_thr = 3'd1;
    check("bp_rdy_a", 32'(in_ready), 1);
    tick();
    in_thr = 3'd4;
    check("bp_rdy_b", 32'(in_ready), 1);
    tick();
    in_thr = 3'd5;
    check("bp_rdy_c", 32'(in_ready), 0);
    check("bp_hold0", 32'(out_data), 32'hF);
    tick();
    check("bp_hold1", 32'(out_data), 32'hF);
    check("bp_rdy_c2", 32'(in_ready), 0);
    tick();
    check("bp_hold2", 32'(out_data), 32'hF);
    out_ready = 1'b1;
    #1 check("bp_release_rdy", 32'(in_ready), 1);
    tick();
    in_valid = 1'b0;
    check("bp_beat2", 32'(out_data), 32'h8);
    tick();
    check("bp_beat3_v", 32'(out_valid), 1);
    check("bp_beat3", 32'(out_data), 32'h0);
    tick();
    check("bp_empty", 32'(out_valid), 0);

    // Counter clear, unanimous beat, saturation
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    check("clr_cnt", 32'(dissent_cnt), 0);
    in_valid = 1'b1; in_data = ALL1; in_thr = '0;
    tick();
    in_valid = 1'b0;
    tick();
    check("unan_data", 32'(out_data), 32'hF);
    check("unan_flag", 32'(out_unan), 1);
    tick();
    check("unan_cnt", 32'(dissent_cnt), 0);
    in_valid = 1'b1; in_data = VOTERS;
    repeat (5) tick();
    in_valid = 1'b0;
    repeat (3) tick();
    check("sat_cnt", 32'(dissent_cnt), 3);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    check("clr_hs_valid", 32'(out_valid), 1);
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    check("clr_wins", 32'(dissent_cnt), 0);

    // Asynchronous reset with both stages full
    out_ready = 1'b0; in_valid = 1'b1; in_thr = 3'd1;
    tick();
    in_thr = 3'd4;
    tick();
    in_valid = 1'b0;
    check("full_valid", 32'(out_valid), 1);
    check("full_rdy", 32'(in_ready), 0);
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid", 32'(out_valid), 0);
    check("arst_data", 32'(out_data), 0);
    check("arst_rdy", 32'(in_ready), 1);
    @(posedge clk);
    #1 rst_n = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("post_rst_valid", 32'(out_valid), 0);
    end
    check("post_rst_cnt", 32'(dissent_cnt), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

endmodule
